// File: rtl/ahb_enum.sv
// ahb_enum: AHB-Lite response and transfer-type encodings.
package ahb_enum;
  localparam logic [1:0] AHB_RESP_OKAY    = 2'b00;
  localparam logic [1:0] AHB_TRANS_IDLE   = 2'b00;
  localparam logic [1:0] AHB_TRANS_BUSY   = 2'b01;
  localparam logic [1:0] AHB_TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] AHB_TRANS_SEQ    = 2'b11;
endpackage

// File: rtl/iopmp_pkg.sv
// iopmp_pkg: IOPMP violation-log entry type, register offsets and STATUS bit positions.
// The ts field exists only when IOPMP_LOG_TS_EN is defined.
package iopmp_pkg;
  localparam int LOG_AW = 32;
  typedef struct packed {
`ifdef IOPMP_LOG_TS_EN
    logic [31:0]       ts;
`endif
    logic              port;
    logic              write;
    logic [LOG_AW-1:0] addr;
  } iopmp_log_entry_t;
  localparam logic [7:0] REG_CTRL     = 8'h00;
  localparam logic [7:0] REG_STATUS   = 8'h04;
  localparam logic [7:0] REG_HEAD_ADR = 8'h08;
  localparam logic [7:0] REG_HEAD_INF = 8'h0C;
  localparam logic [7:0] REG_POP      = 8'h10;
  localparam logic [7:0] REG_DROP_CNT = 8'h14;
  localparam logic [7:0] REG_HEAD_TS  = 8'h18;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_COUNT = 8;
endpackage

// File: rtl/iopmp_log_fifo.sv
// iopmp_log_fifo: 2-push/1-pop log FIFO; pop is applied before push0, push0 before push1.
module iopmp_log_fifo
  import iopmp_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             hclk,
  input  logic             hresetn,
  input  logic             i_pop,
  input  logic             i_push0,
  input  logic             i_push1,
  input  iopmp_log_entry_t i_din0,
  input  iopmp_log_entry_t i_din1,
  output iopmp_log_entry_t o_head,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_drop0,
  output logic             o_drop1
);
  iopmp_log_entry_t r_mem [DEPTH];
  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_c1;
  logic [CW-1:0]    w_c2;
  logic             w_pop;
  logic             w_ok0;
  logic             w_ok1;

  // free space is re-evaluated after each earlier op in the cycle
  assign w_pop   = i_pop && r_cnt != '0;
  assign w_c1    = r_cnt - CW'(w_pop);
  assign w_ok0   = i_push0 && w_c1 < CW'(DEPTH);
  assign w_c2    = w_c1 + CW'(w_ok0);
  assign w_ok1   = i_push1 && w_c2 < CW'(DEPTH);
  assign o_head  = r_mem[r_rp];
  assign o_count = r_cnt;
  assign o_full  = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_drop0 = i_push0 && !w_ok0;
  assign o_drop1 = i_push1 && !w_ok1;

  always_ff @(posedge hclk) begin
    if (w_ok0) r_mem[r_wp] <= i_din0;
    if (w_ok1) r_mem[r_wp + PW'(w_ok0)] <= i_din1;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= r_wp + PW'(w_ok0) + PW'(w_ok1);
      r_rp  <= r_rp + PW'(w_pop);
      r_cnt <= w_c2 + CW'(w_ok1);
    end
  end
endmodule

// File: rtl/ahb_iopmp_log.sv
// ahb_iopmp_log: AHB-Lite register slave draining a FIFO of IOPMP-blocked transfers, level IRQ while pending.
// Defining IOPMP_LOG_TS_EN stamps each entry with a free-running cycle count readable at 0x18.
module ahb_iopmp_log
  import ahb_enum::*, iopmp_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [2:0]            hsize,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic                  hwrite,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic [1:0]            hresp,
  output logic                  hready,
  output logic [DATA_WIDTH-1:0] hrdata,
  input  logic                  v0_valid,
  input  logic [ADDR_WIDTH-1:0] v0_addr,
  input  logic                  v0_write,
  input  logic                  v1_valid,
  input  logic [ADDR_WIDTH-1:0] v1_addr,
  input  logic                  v1_write,
  output logic                  irq
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic                  r_wr;
  logic [7:0]            r_wa;
  logic                  r_ctrl;
  logic                  r_ovf;
  logic [15:0]           r_drop;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_act;
  logic                  w_pop;
  logic                  w_clr;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_drop0;
  logic                  w_drop1;
  logic                  w_unused;
  logic [1:0]            w_ndrop;
  logic [16:0]           w_dsum;
  logic [CW-1:0]         w_count;
  logic [31:0]           w_status;
  logic [31:0]           w_ts;
  logic [31:0]           w_rd;
  iopmp_log_entry_t      w_din0;
  iopmp_log_entry_t      w_din1;
  iopmp_log_entry_t      w_head;

  assign hresp    = AHB_RESP_OKAY;
  assign hready   = 1'b1;
  assign hrdata   = r_rdata;
  assign irq      = r_ctrl && !w_empty;
  assign w_act    = hsel && (htrans == AHB_TRANS_NONSEQ || htrans == AHB_TRANS_SEQ);
  assign w_pop    = r_wr && r_wa == REG_POP;
  assign w_clr    = w_pop && hwdata[31];
  assign w_ndrop  = {1'b0, w_drop0} + {1'b0, w_drop1};
  // a clear restarts the count from this cycle's drops, so a same-cycle drop survives it
  assign w_dsum   = (w_clr ? 17'd0 : {1'b0, r_drop}) + {15'd0, w_ndrop};
  assign w_unused = ^{hsize, hburst, hprot, haddr, hwdata};

`ifdef IOPMP_LOG_TS_EN
  logic [31:0] r_ts;
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) r_ts <= '0;
    else r_ts <= r_ts + 32'd1;
  end
  assign w_din0 = '{ts: r_ts, port: 1'b0, write: v0_write, addr: LOG_AW'(v0_addr)};
  assign w_din1 = '{ts: r_ts, port: 1'b1, write: v1_write, addr: LOG_AW'(v1_addr)};
  assign w_ts   = w_empty ? '0 : w_head.ts;
`else
  assign w_din0 = '{port: 1'b0, write: v0_write, addr: LOG_AW'(v0_addr)};
  assign w_din1 = '{port: 1'b1, write: v1_write, addr: LOG_AW'(v1_addr)};
  assign w_ts   = '0;
`endif

  iopmp_log_fifo #(.DEPTH(DEPTH)) u_fifo (
    .hclk    (hclk),
    .hresetn (hresetn),
    .i_pop   (w_pop),
    .i_push0 (v0_valid),
    .i_push1 (v1_valid),
    .i_din0  (w_din0),
    .i_din1  (w_din1),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_drop0 (w_drop0),
    .o_drop1 (w_drop1)
  );

  always_comb begin
    w_status                 = '0;
    w_status[ST_EMPTY]       = w_empty;
    w_status[ST_FULL]        = w_full;
    w_status[ST_OVF]         = r_ovf;
    w_status[ST_COUNT +: CW] = w_count;
  end

  assign w_rd = haddr[7:0] == REG_CTRL     ? {31'd0, r_ctrl} :
                haddr[7:0] == REG_STATUS   ? w_status :
                haddr[7:0] == REG_HEAD_ADR ? (w_empty ? '0 : w_head.addr) :
                haddr[7:0] == REG_HEAD_INF ? (w_empty ? '0 : {30'd0, w_head.port, w_head.write}) :
                haddr[7:0] == REG_DROP_CNT ? {16'd0, r_drop} :
                haddr[7:0] == REG_HEAD_TS  ? w_ts : '0;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_wr    <= 1'b0;
      r_wa    <= '0;
      r_ctrl  <= 1'b0;
      r_ovf   <= 1'b0;
      r_drop  <= '0;
      r_rdata <= '0;
    end else begin
      r_wr    <= w_act && hwrite;
      r_wa    <= haddr[7:0];
      if (r_wr && r_wa == REG_CTRL) r_ctrl <= hwdata[0];
      r_ovf   <= (r_ovf && !w_clr) || w_ndrop != 2'd0;
      r_drop  <= w_dsum[16] ? 16'hFFFF : w_dsum[15:0];
      if (w_act && !hwrite) r_rdata <= DATA_WIDTH'(w_rd);
    end
  end
endmodule

// File: tb/tb_ahb_iopmp_log.sv
// tb_ahb_iopmp_log: directed and randomized checks of the violation logger against a queue-based model.
module tb_ahb_iopmp_log;
  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel = 1'b0;
  logic        hwrite = 1'b0;
  logic [31:0] haddr = '0;
  logic [31:0] hwdata = '0;
  logic [2:0]  hsize = 3'd2;
  logic [2:0]  hburst = 3'd0;
  logic [1:0]  htrans = 2'b00;
  logic [3:0]  hprot = 4'h3;
  logic [1:0]  hresp;
  logic        hready;
  logic [31:0] hrdata;
  logic        v0_valid = 1'b0;
  logic        v0_write = 1'b0;
  logic [31:0] v0_addr = '0;
  logic        v1_valid = 1'b0;
  logic        v1_write = 1'b0;
  logic [31:0] v1_addr = '0;
  logic        irq;

  always #5 hclk = ~hclk;

  ahb_iopmp_log dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .hsize(hsize),
    .htrans(htrans), .hburst(hburst), .hprot(hprot), .hwrite(hwrite), .hwdata(hwdata),
    .hresp(hresp), .hready(hready), .hrdata(hrdata),
    .v0_valid(v0_valid), .v0_addr(v0_addr), .v0_write(v0_write),
    .v1_valid(v1_valid), .v1_addr(v1_addr), .v1_write(v1_write), .irq(irq)
  );

  typedef struct { bit port; bit wr; logic [31:0] addr; } ent_t;
  ent_t        q[$];
  bit          m_ctrl;
  bit          m_ovf;
  int          m_drop;
  bit          p_wr;
  logic [7:0]  p_addr;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_exp(input logic [7:0] a);
    case (a)
      8'h00: return 32'(m_ctrl);
      8'h04: return (32'(q.size()) << 8) | (32'(m_ovf) << 2) | (32'(q.size() == 8) << 1) | 32'(q.size() == 0);
      8'h08: return q.size() != 0 ? q[0].addr : 32'h0;
      8'h0C: return q.size() != 0 ? {30'd0, q[0].port, q[0].wr} : 32'h0;
      8'h14: return 32'(m_drop);
      default: return 32'h0;
    endcase
  endfunction

  function automatic int mpush(input bit v, input bit port, input bit w, input logic [31:0] a);
    if (!v) return 0;
    if (q.size() < 8) begin
      q.push_back('{port, w, a});
      return 0;
    end
    return 1;
  endfunction

  // one clock: sel/wr/a form an address phase, wd is the data phase of the previous write
  task automatic step(input bit sel, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                      input bit v0, input logic [31:0] a0, input bit w0,
                      input bit v1, input logic [31:0] a1, input bit w1);
    logic [31:0] exp_rd;
    bit          clr;
    int          nd;
    @(negedge hclk);
    hsel = sel; hwrite = wr; htrans = sel ? 2'b10 : 2'b00; haddr = {24'h0, a}; hwdata = wd;
    v0_valid = v0; v0_addr = a0; v0_write = w0; v1_valid = v1; v1_addr = a1; v1_write = w1;
    exp_rd = rd_exp(a);
    clr = 1'b0;
    if (p_wr && p_addr == 8'h00) m_ctrl = wd[0];
    if (p_wr && p_addr == 8'h10) begin
      if (q.size() != 0) q.delete(0);
      clr = wd[31];
    end
    nd = mpush(v0, 1'b0, w0, a0);
    nd += mpush(v1, 1'b1, w1, a1);
    if (clr) begin
      m_ovf = nd != 0;
      m_drop = nd;
    end else begin
      m_ovf = m_ovf || nd != 0;
      m_drop = (m_drop + nd > 65535) ? 65535 : m_drop + nd;
    end
    p_wr = sel && wr;
    p_addr = a;
    @(posedge hclk);
    #1;
    if (sel && !wr) begin
      last_rd = hrdata;
      check($sformatf("rd_%02h", a), hrdata, exp_rd);
    end
    check("irq", 32'(irq), 32'(m_ctrl && q.size() != 0));
  endtask

  task automatic idle();
    step(0, 0, 8'h0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);
  endtask

  task automatic rd(input logic [7:0] a);
    step(1, 0, a, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);
  endtask

  task automatic chk_rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    rd(a);
    check(tag, last_rd, exp);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    step(1, 1, a, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);
    step(0, 0, 8'h0, d, 0, 32'h0, 0, 0, 32'h0, 0);
  endtask

  task automatic viol(input bit v0, input logic [31:0] a0, input bit w0,
                      input bit v1, input logic [31:0] a1, input bit w1);
    step(0, 0, 8'h0, 32'h0, v0, a0, w0, v1, a1, w1);
  endtask

  task automatic do_reset();
    @(negedge hclk);
    hresetn = 1'b0; hsel = 1'b0; htrans = 2'b00; v0_valid = 1'b0; v1_valid = 1'b0;
    #1;
    check("rst_hrdata", hrdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    q.delete();
    m_ctrl = 0; m_ovf = 0; m_drop = 0; p_wr = 0; p_addr = '0;
    repeat (2) @(negedge hclk);
    hresetn = 1'b1;
  endtask

  initial begin
    do_reset();
    chk_rd("status_reset", 8'h04, 32'h1);
    chk_rd("head_adr_reset", 8'h08, 32'h0);

    viol(1, 32'h2000_0040, 1, 0, 32'h0, 0);
    wr(8'h00, 32'h1);
    check("irq_pending", 32'(irq), 32'h1);
    chk_rd("head_adr_v0", 8'h08, 32'h2000_0040);
    chk_rd("head_inf_v0", 8'h0C, 32'h1);
    wr(8'h10, 32'h0);
    chk_rd("status_after_pop", 8'h04, 32'h1);
    check("irq_drained", 32'(irq), 32'h0);

    viol(1, 32'h100, 0, 1, 32'h200, 0);
    chk_rd("status_two", 8'h04, 32'h200);
    chk_rd("head_adr_p0", 8'h08, 32'h100);
    chk_rd("head_inf_p0", 8'h0C, 32'h0);
    wr(8'h10, 32'h0);
    chk_rd("head_adr_p1", 8'h08, 32'h200);
    chk_rd("head_inf_p1", 8'h0C, 32'h2);
    wr(8'h10, 32'h0);

    for (int i = 0; i < 9; i++) viol(1, 32'h1000 + 32'(i), 0, 0, 32'h0, 0);
    chk_rd("status_full_ovf", 8'h04, 32'h806);
    chk_rd("drop_one", 8'h14, 32'h1);
    wr(8'h10, 32'h8000_0000);
    chk_rd("status_after_clr", 8'h04, 32'h700);
    chk_rd("drop_cleared", 8'h14, 32'h0);

    viol(1, 32'h1100, 0, 0, 32'h0, 0);
    step(1, 1, 8'h10, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);
    step(0, 0, 8'h0, 32'h0, 0, 32'h0, 0, 1, 32'hABC, 0);
    chk_rd("status_full_pop_push", 8'h04, 32'h802);
    chk_rd("drop_none", 8'h14, 32'h0);
    for (int i = 0; i < 7; i++) wr(8'h10, 32'h0);
    chk_rd("tail_adr", 8'h08, 32'hABC);
    chk_rd("tail_inf", 8'h0C, 32'h2);
    chk_rd("head_ts_absent", 8'h18, 32'h0);
    chk_rd("unmapped", 8'h1C, 32'h0);

    for (int i = 0; i < 33000; i++) viol(1, 32'h3000, 1, 1, 32'h4000, 0);
    chk_rd("drop_saturated", 8'h14, 32'hFFFF);
    step(1, 1, 8'h10, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);
    step(0, 0, 8'h0, 32'h8000_0000, 1, 32'h300, 0, 1, 32'h400, 1);
    chk_rd("status_clr_vs_drop", 8'h04, 32'h806);
    chk_rd("drop_clr_vs_drop", 8'h14, 32'h1);

    for (int i = 0; i < 600; i++) begin
      int         op;
      bit         sel;
      bit         w;
      logic [7:0] a;
      op = $urandom_range(0, 9);
      sel = op < 8;
      w = op >= 4 && op < 8;
      a = w ? (op < 6 ? 8'h10 : (op == 6 ? 8'h00 : 8'h04)) : 8'($urandom_range(0, 7) * 4);
      step(sel, w, a, $urandom, $urandom_range(0, 9) < 4, $urandom, 1'($urandom),
           $urandom_range(0, 9) < 4, $urandom, 1'($urandom));
    end
    idle();

    viol(1, 32'h5000, 1, 1, 32'h6000, 1);
    wr(8'h00, 32'h1);
    do_reset();
    chk_rd("status_midreset", 8'h04, 32'h1);
    chk_rd("ctrl_midreset", 8'h00, 32'h0);
    chk_rd("drop_midreset", 8'h14, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
